// File: rtl/kpn_channel_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : kpn_channel_arbiter_if
//  Purpose  : Bundles the producer, consumer and channel-FIFO signals of the
//             KPN channel arbiter.
//  Ports    : req_0/req_1, data_0/data_1  producer requests and tokens
//             gnt_0/gnt_1                 per-producer accept strobes
//             fifo_wr, fifo_data          write side of the channel FIFO
//             rd_req, fifo_rd             consumer request / read strobe
//             count, full, empty          FIFO occupancy status
//  Modports : master = arbiter side, slave = producers/consumer/FIFO side
//  Revision : 1.0  initial release
// ============================================================================
interface kpn_channel_arbiter_if #(
  parameter int BITS_NUMBER   = 16,
  parameter int FIFO_ELEMENTS = 5
);
  logic                     req_0;
  logic                     req_1;
  logic [BITS_NUMBER-1:0]   data_0;
  logic [BITS_NUMBER-1:0]   data_1;
  logic                     gnt_0;
  logic                     gnt_1;
  logic                     fifo_wr;
  logic [BITS_NUMBER-1:0]   fifo_data;
  logic                     rd_req;
  logic                     fifo_rd;
  logic [FIFO_ELEMENTS:0]   count;
  logic                     full;
  logic                     empty;

  modport master (
    input  req_0, req_1, data_0, data_1, rd_req,
    output gnt_0, gnt_1, fifo_wr, fifo_data, fifo_rd, count, full, empty
  );

  modport slave (
    output req_0, req_1, data_0, data_1, rd_req,
    input  gnt_0, gnt_1, fifo_wr, fifo_data, fifo_rd, count, full, empty
  );
endinterface
`default_nettype wire

// File: rtl/kpn_channel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : kpn_channel_arbiter
//  Purpose  : Two-producer write arbiter for a KPN channel FIFO. Ownership is
//             granted per producer for bursts of up to MAX_BURST tokens,
//             alternating fairly when both producers request. Also tracks the
//             FIFO occupancy and gates the consumer read strobe.
//  Ports    : clk    single clock, rising edge
//             reset  synchronous, active-high
//             bus    kpn_channel_arbiter_if.master (producer/consumer/FIFO)
//  Revision : 1.0  initial release
// ============================================================================
module kpn_channel_arbiter #(
  parameter int BITS_NUMBER   = 16,
  parameter int FIFO_ELEMENTS = 5,
  parameter int MAX_BURST     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  kpn_channel_arbiter_if.master  bus
);

  localparam int CW = FIFO_ELEMENTS + 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] C_CAP       = CW'(1 << FIFO_ELEMENTS);
  localparam logic [BW-1:0] C_MAX_BURST = BW'(MAX_BURST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_last;       // last owner: 0 or 1
  logic                   w_last_nxt;
  logic [BW-1:0]          r_burst;
  logic [BW-1:0]          w_burst_nxt;
  logic [BW-1:0]          w_burst_inc;
  logic [CW-1:0]          r_count;

  logic                   w_room;
  logic                   w_gnt0;
  logic                   w_gnt1;
  logic                   w_leave;
  logic                   w_wr;
  logic                   w_rd;
  logic [BITS_NUMBER-1:0] w_data;

  assign w_room      = (r_count != C_CAP);
  assign w_burst_inc = r_burst + 1'b1;

  // --------------------------------------------------------------------------
  // Next-state and grant logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_burst_nxt = r_burst;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_leave     = 1'b0;
    w_data      = bus.data_0;

    case (r_state)
      S_IDLE: begin
        // On a tie the producer that did not own last time wins.
        if (bus.req_0 && (!bus.req_1 || r_last)) begin
          w_state_nxt = S_OWN0;
          w_last_nxt  = 1'b0;
          w_burst_nxt = '0;
        end else if (bus.req_1) begin
          w_state_nxt = S_OWN1;
          w_last_nxt  = 1'b1;
          w_burst_nxt = '0;
        end
      end

      S_OWN0: begin
        w_gnt0  = bus.req_0 & w_room;
        // A full FIFO stalls the owner without consuming burst budget.
        w_leave = !bus.req_0 || (w_gnt0 && (w_burst_inc == C_MAX_BURST));
        if (w_gnt0) begin
          w_burst_nxt = w_burst_inc;
        end
        if (w_leave) begin
          if (bus.req_1) begin
            w_state_nxt = S_OWN1;
            w_last_nxt  = 1'b1;
            w_burst_nxt = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_OWN1: begin
        w_data  = bus.data_1;
        w_gnt1  = bus.req_1 & w_room;
        w_leave = !bus.req_1 || (w_gnt1 && (w_burst_inc == C_MAX_BURST));
        if (w_gnt1) begin
          w_burst_nxt = w_burst_inc;
        end
        if (w_leave) begin
          if (bus.req_0) begin
            w_state_nxt = S_OWN0;
            w_last_nxt  = 1'b0;
            w_burst_nxt = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // While reset is asserted the state register may still hold an owner;
    // suppress everything it would otherwise drive.
    if (reset) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      w_data = bus.data_0;
    end
  end

  assign w_wr = w_gnt0 | w_gnt1;
  assign w_rd = bus.rd_req & (r_count != '0) & ~reset;

  // --------------------------------------------------------------------------
  // State, ownership history, burst counter and occupancy registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_burst <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_burst <= w_burst_nxt;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.gnt_0     = w_gnt0;
  assign bus.gnt_1     = w_gnt1;
  assign bus.fifo_wr   = w_wr;
  assign bus.fifo_data = w_data;
  assign bus.fifo_rd   = w_rd;
  assign bus.count     = r_count;
  // Forced to the empty view during reset so the status never shows stale
  // occupancy from an abandoned session.
  assign bus.empty     = (r_count == '0) | reset;
  assign bus.full      = (r_count == C_CAP) & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_kpn_channel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kpn_channel_arbiter
//  Purpose  : Self-checking bench for kpn_channel_arbiter. A driver issues
//             per-cycle stimulus and pushes the reference model's expected
//             outputs into a scoreboard queue; a monitor pops and compares on
//             the falling edge. Directed phases cover the boundary scenarios,
//             followed by randomized traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_kpn_channel_arbiter;

  localparam int BITS = 16;
  localparam int FE   = 5;
  localparam int CAP  = 1 << FE;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  kpn_channel_arbiter_if #(.BITS_NUMBER(BITS), .FIFO_ELEMENTS(FE)) bus ();

  kpn_channel_arbiter #(
    .BITS_NUMBER   (BITS),
    .FIFO_ELEMENTS (FE),
    .MAX_BURST     (MAXB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic            g0;
    logic            g1;
    logic            wr;
    logic            rd;
    logic            empty;
    logic            full;
    logic [BITS-1:0] data;
    int              count;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner (-1 = nobody), last owner, tokens taken in the
  // current ownership, and FIFO occupancy.
  int m_owner = -1;
  int m_last  = 1;
  int m_taken = 0;
  int m_occ   = 0;
  bit m_valid = 0;

  logic [BITS-1:0] base0 = 16'h0010;
  int              seq0  = 0;
  int              seq1  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void take(int k);
    m_owner = k;
    m_last  = k;
    m_taken = 0;
  endfunction

  // One clock cycle of stimulus; computes the expected outputs for this cycle
  // from the model and then advances the model across the coming edge.
  task automatic cycle(input bit r0, input bit r1, input bit rd, input bit rs);
    exp_t e;
    logic [BITS-1:0] d0, d1;
    bit own_req, oth_req, leave;
    @(posedge clk);
    #1;
    d0 = base0 + BITS'(seq0);
    d1 = 16'h8000 + BITS'(seq1);
    bus.req_0  = r0;
    bus.req_1  = r1;
    bus.rd_req = rd;
    bus.data_0 = d0;
    bus.data_1 = d1;
    reset      = rs;

    e.count = m_occ;
    if (rs) begin
      e.g0 = 0; e.g1 = 0; e.rd = 0; e.empty = 1; e.full = 0; e.data = d0;
    end else begin
      e.g0    = (m_owner == 0) && r0 && (m_occ < CAP);
      e.g1    = (m_owner == 1) && r1 && (m_occ < CAP);
      e.rd    = rd && (m_occ != 0);
      e.empty = (m_occ == 0);
      e.full  = (m_occ == CAP);
      e.data  = (m_owner == 1) ? d1 : d0;
    end
    e.wr = e.g0 | e.g1;
    if (m_valid) sb.push_back(e);

    if (rs) begin
      m_owner = -1; m_last = 1; m_taken = 0; m_occ = 0; m_valid = 1;
    end else begin
      m_occ = m_occ + int'(e.wr) - int'(e.rd);
      if (m_owner < 0) begin
        if (r0 && r1) take(m_last == 1 ? 0 : 1);
        else if (r0)  take(0);
        else if (r1)  take(1);
      end else begin
        own_req = (m_owner == 0) ? r0 : r1;
        oth_req = (m_owner == 0) ? r1 : r0;
        leave   = !own_req;
        if (e.wr) begin
          m_taken++;
          if (m_taken == MAXB) leave = 1;
        end
        if (leave) begin
          if (oth_req) take(1 - m_owner);
          else         m_owner = -1;
        end
      end
    end
    if (e.g0) seq0++;
    if (e.g1) seq1++;
  endtask

  // Monitor: compare every registered expectation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("gnt_0",     32'(bus.gnt_0),     32'(e.g0));
        chk("gnt_1",     32'(bus.gnt_1),     32'(e.g1));
        chk("fifo_wr",   32'(bus.fifo_wr),   32'(e.wr));
        chk("fifo_rd",   32'(bus.fifo_rd),   32'(e.rd));
        chk("fifo_data", 32'(bus.fifo_data), 32'(e.data));
        chk("count",     32'(bus.count),     32'(e.count));
        chk("empty",     32'(bus.empty),     32'(e.empty));
        chk("full",      32'(bus.full),      32'(e.full));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int prd, preq;
    bus.req_0 = 0; bus.req_1 = 0; bus.rd_req = 0;
    bus.data_0 = '0; bus.data_1 = '0;
    reset = 1;

    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);

    // Single producer streaming: 1 idle cycle, burst of 4, idle, re-own.
    base0 = 16'h0010; seq0 = 0;
    cycle(1, 0, 0, 0);
    #1;
    chk("rst_empty",  32'(bus.empty), 32'd1);
    chk("rst_count",  32'(bus.count), 32'd0);
    chk("rst_no_gnt", 32'(bus.gnt_0), 32'd0);
    cycle(1, 0, 0, 0);
    #1;
    chk("first_gnt0", 32'(bus.gnt_0), 32'd1);
    chk("first_data", 32'(bus.fifo_data), 32'h0010);
    repeat (4) cycle(1, 0, 0, 0);
    #1;
    chk("burst_count", 32'(bus.count), 32'd4);
    chk("burst_idle",  32'(bus.gnt_0), 32'd0);
    repeat (6) cycle(1, 0, 0, 0);

    // Both producers: producer 0 first, back-to-back bursts of 4.
    cycle(0, 0, 0, 1);
    repeat (6) cycle(1, 1, 0, 0);
    #1;
    chk("alt_gnt1", 32'(bus.gnt_1), 32'd1);
    chk("alt_gnt0", 32'(bus.gnt_0), 32'd0);
    repeat (18) cycle(1, 1, 0, 0);

    // Fill to capacity from producer 1.
    cycle(0, 0, 0, 1);
    repeat (45) cycle(0, 1, 0, 0);
    #1;
    chk("fill_count", 32'(bus.count),   32'(CAP));
    chk("fill_full",  32'(bus.full),    32'd1);
    chk("fill_gnt1",  32'(bus.gnt_1),   32'd0);
    chk("fill_wr",    32'(bus.fifo_wr), 32'd0);

    // Read and write request together while full.
    cycle(1, 0, 1, 0);
    #1;
    chk("full_rd", 32'(bus.fifo_rd), 32'd1);
    chk("full_wr", 32'(bus.fifo_wr), 32'd0);
    cycle(1, 0, 1, 0);
    #1;
    chk("both_rd",    32'(bus.fifo_rd), 32'd1);
    chk("both_wr",    32'(bus.fifo_wr), 32'd1);
    chk("both_count", 32'(bus.count),   32'(CAP - 1));
    cycle(1, 0, 1, 0);
    #1;
    chk("both_hold", 32'(bus.count), 32'(CAP - 1));

    // Read request while empty, with a write in the same cycle.
    cycle(0, 0, 0, 1);
    cycle(1, 0, 1, 0);
    cycle(1, 0, 1, 0);
    #1;
    chk("empty_rd", 32'(bus.fifo_rd), 32'd0);
    chk("empty_wr", 32'(bus.fifo_wr), 32'd1);
    cycle(1, 0, 1, 0);
    #1;
    chk("one_count", 32'(bus.count),   32'd1);
    chk("one_rd",    32'(bus.fifo_rd), 32'd1);

    // Reset in the middle of an OWN1 burst.
    cycle(0, 0, 0, 1);
    repeat (3) cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 1);
    #1;
    chk("mid_rst_gnt", 32'(bus.gnt_1), 32'd0);
    cycle(0, 1, 0, 0);
    #1;
    chk("post_rst_count", 32'(bus.count),   32'd0);
    chk("post_rst_empty", 32'(bus.empty),   32'd1);
    chk("post_rst_gnt1",  32'(bus.gnt_1),   32'd0);
    chk("post_rst_wr",    32'(bus.fifo_wr), 32'd0);
    chk("post_rst_rd",    32'(bus.fifo_rd), 32'd0);

    // Randomized traffic in segments with different read/request pressure.
    for (int seg = 0; seg < 6; seg++) begin
      prd  = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
      preq = (seg < 3) ? 85 : 50;
      for (int i = 0; i < 500; i++) begin
        cycle(($urandom_range(0, 99) < preq),
              ($urandom_range(0, 99) < preq),
              ($urandom_range(0, 99) < prd),
              ($urandom_range(0, 299) == 0));
      end
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
